// File: rtl/branch_target_table.sv
// rtl/branch_target_table.sv - run-time programmable label-to-PC branch target table
// Define BTT_WR_BYPASS_EN to have a same-cycle write forwarded to a read of the same label.
module branch_target_table #(
  parameter int LABEL_W    = 8,
  parameter int PC_W       = 12,
  parameter int DEPTH      = 64,
  parameter int DEFAULT_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ready,
  input  logic               wr_en,
  input  logic [LABEL_W-1:0] wr_label,
  input  logic [PC_W-1:0]    wr_target,
  input  logic               wr_inval,
  input  logic               rd_req,
  input  logic [LABEL_W-1:0] rd_label,
  output logic               rd_valid,
  output logic [PC_W-1:0]    rd_target,
  output logic               rd_hit
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LABEL_W:0]  DEPTH_L  = (LABEL_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [PC_W-1:0]   DEF_PC   = PC_W'(DEFAULT_PC);

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  sweep_idx;
  logic [DEPTH-1:0]  valid;
  logic [PC_W-1:0]   targets [DEPTH];

  logic              wr_in_range, rd_in_range, wr_fire, rd_fire;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              lookup_hit;
  logic [PC_W-1:0]   lookup_target;

  assign wr_in_range = ({1'b0, wr_label} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_label} < DEPTH_L);
  assign wr_idx      = wr_label[IDX_W-1:0];
  assign rd_idx      = rd_label[IDX_W-1:0];
  assign wr_fire     = (state == READY) && wr_en && wr_in_range;
  assign rd_fire     = (state == READY) && rd_req;

  always_comb begin
    lookup_hit    = 1'b0;
    lookup_target = DEF_PC;
    if (rd_in_range && valid[rd_idx]) begin
      lookup_hit    = 1'b1;
      lookup_target = targets[rd_idx];
    end
`ifdef BTT_WR_BYPASS_EN
    // Forward the write that lands on this same edge so the read sees its effect.
    if (wr_fire && rd_in_range && (wr_label == rd_label)) begin
      lookup_hit    = !wr_inval;
      lookup_target = wr_inval ? DEF_PC : wr_target;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      sweep_idx <= '0;
      ready     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_target <= DEF_PC;
      rd_hit    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          valid[sweep_idx] <= 1'b0;
          rd_valid         <= 1'b0;
          if (sweep_idx == LAST_IDX) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        READY: begin
          if (wr_fire) begin
            valid[wr_idx] <= !wr_inval;
            if (!wr_inval) targets[wr_idx] <= wr_target;
          end
          rd_valid <= rd_fire;
          if (rd_fire) begin
            rd_target <= lookup_target;
            rd_hit    <= lookup_hit;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_target_table.sv
// tb/tb_branch_target_table.sv - directed self-checking bench for branch_target_table
module tb_branch_target_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        wr_en;
  logic [7:0]  wr_label;
  logic [11:0] wr_target;
  logic        wr_inval;
  logic        rd_req;
  logic [7:0]  rd_label;
  logic        rd_valid;
  logic [11:0] rd_target;
  logic        rd_hit;

  int n_cmp = 0;
  int n_err = 0;

  branch_target_table #(.LABEL_W(8), .PC_W(12), .DEPTH(64), .DEFAULT_PC(0)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .wr_en(wr_en), .wr_label(wr_label), .wr_target(wr_target), .wr_inval(wr_inval),
    .rd_req(rd_req), .rd_label(rd_label),
    .rd_valid(rd_valid), .rd_target(rd_target), .rd_hit(rd_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write(input int label, input int target, input bit inval);
    wr_en = 1'b1; wr_label = 8'(label); wr_target = 12'(target); wr_inval = inval;
    tick();
    wr_en = 1'b0; wr_inval = 1'b0;
  endtask

  task automatic read_check(input string tag, input int label, input int exp_t, input bit exp_h);
    rd_req = 1'b1; rd_label = 8'(label);
    tick();
    rd_req = 1'b0;
    check({tag, ".valid"}, int'(rd_valid), 1);
    check({tag, ".target"}, int'(rd_target), exp_t);
    check({tag, ".hit"}, int'(rd_hit), int'(exp_h));
  endtask

  initial begin
    int seen_ready;
    int seen_valid;
    int waited;
    reset = 1'b1; wr_en = 1'b0; wr_label = '0; wr_target = '0; wr_inval = 1'b0;
    rd_req = 1'b0; rd_label = '0;
    tick(); tick();
    check("rst.ready", int'(ready), 0);
    check("rst.rd_valid", int'(rd_valid), 0);
    check("rst.rd_target", int'(rd_target), 0);
    check("rst.rd_hit", int'(rd_hit), 0);

    // Sweep: ready low for 64 cycles; a request mid-sweep is ignored.
    reset = 1'b0;
    seen_ready = 0; seen_valid = 0;
    for (int i = 1; i <= 63; i++) begin
      rd_req = (i >= 30 && i <= 32); rd_label = 8'd3;
      tick();
      if (ready) seen_ready++;
      if (rd_valid) seen_valid++;
    end
    rd_req = 1'b0;
    check("sweep.ready_early", seen_ready, 0);
    check("sweep.rd_valid", seen_valid, 0);
    tick();
    check("sweep.ready_at_64", int'(ready), 1);

    // Program and back-to-back reads.
    write(3, 208, 0);
    write(17, 625, 0);
    rd_req = 1'b1; rd_label = 8'd3;
    tick();
    check("b2b0.valid", int'(rd_valid), 1);
    check("b2b0.target", int'(rd_target), 208);
    check("b2b0.hit", int'(rd_hit), 1);
    rd_label = 8'd17;
    tick();
    check("b2b1.valid", int'(rd_valid), 1);
    check("b2b1.target", int'(rd_target), 625);
    check("b2b1.hit", int'(rd_hit), 1);
    rd_label = 8'd5;
    tick();
    check("b2b2.valid", int'(rd_valid), 1);
    check("b2b2.target", int'(rd_target), 0);
    check("b2b2.hit", int'(rd_hit), 0);
    rd_req = 1'b0;
    tick();
    check("idle.valid", int'(rd_valid), 0);
    read_check("rd3", 3, 208, 1);
    tick();
    check("hold.valid", int'(rd_valid), 0);
    check("hold.target", int'(rd_target), 208);
    check("hold.hit", int'(rd_hit), 1);

    // Out-of-range write is dropped; 70 must not alias onto entry 6.
    write(70, 99, 0);
    read_check("oor70", 70, 0, 0);
    read_check("alias6", 6, 0, 0);
    read_check("keep3", 3, 208, 1);
    read_check("oor255", 255, 0, 0);

    // Invalidate.
    write(4, 221, 0);
    read_check("inv.pre", 4, 221, 1);
    write(4, 999, 1);
    read_check("inv.post", 4, 0, 0);

    // Boundary entries.
    write(63, 4095, 0);
    read_check("last63", 63, 4095, 1);
    write(0, 1, 0);
    read_check("first0", 0, 1, 1);

    // Simultaneous write/read of different labels.
    wr_en = 1'b1; wr_label = 8'd10; wr_target = 12'd400;
    rd_req = 1'b1; rd_label = 8'd3;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    check("diff.target", int'(rd_target), 208);
    check("diff.hit", int'(rd_hit), 1);
    read_check("diff.rd10", 10, 400, 1);

    // Same-label collision.
    write(9, 286, 0);
    wr_en = 1'b1; wr_label = 8'd9; wr_target = 12'd300;
    rd_req = 1'b1; rd_label = 8'd9;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    check("coll.valid", int'(rd_valid), 1);
`ifdef BTT_WR_BYPASS_EN
    check("coll.target", int'(rd_target), 300);
`else
    check("coll.target", int'(rd_target), 286);
`endif
    check("coll.hit", int'(rd_hit), 1);
    read_check("coll.after", 9, 300, 1);

    // Same-label collision with invalidate.
    wr_en = 1'b1; wr_inval = 1'b1; wr_label = 8'd9; wr_target = 12'd77;
    rd_req = 1'b1; rd_label = 8'd9;
    tick();
    wr_en = 1'b0; wr_inval = 1'b0; rd_req = 1'b0;
`ifdef BTT_WR_BYPASS_EN
    check("collinv.target", int'(rd_target), 0);
    check("collinv.hit", int'(rd_hit), 0);
`else
    check("collinv.target", int'(rd_target), 300);
    check("collinv.hit", int'(rd_hit), 1);
`endif
    read_check("collinv.after", 9, 0, 0);

    // Mid-operation reset.
    write(2, 352, 0);
    read_check("pre_rst2", 2, 352, 1);
    reset = 1'b1; rd_req = 1'b1; rd_label = 8'd2;
    tick();
    check("mrst.ready", int'(ready), 0);
    check("mrst.rd_valid", int'(rd_valid), 0);
    check("mrst.rd_target", int'(rd_target), 0);
    reset = 1'b0;
    tick();
    check("mrst.after_valid", int'(rd_valid), 0);
    seen_valid = 0; waited = 1;
    while (!ready && waited < 200) begin
      tick();
      waited++;
      if (rd_valid) seen_valid++;
    end
    check("mrst.ready_wait", int'(ready), 1);
    check("mrst.sweep_cycles", waited, 64);
    check("mrst.sweep_valid", seen_valid, 0);
    tick();
    rd_req = 1'b0;
    check("mrst.rd2.valid", int'(rd_valid), 1);
    check("mrst.rd2.target", int'(rd_target), 0);
    check("mrst.rd2.hit", int'(rd_hit), 0);
    read_check("mrst.rd3", 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
